// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
// Bundles the two requester ports, the RAM port and the busy flag of
// dmem_arbiter into a single interface.
//
// Handshake (both requesters): a requester raises reqX with weX/addrX/
// wmaskX/wdataX stable and keeps them stable until the cycle in which gntX
// is high; that cycle is the transfer. Exactly one rvalidX pulse follows one
// cycle later (read data on rdataX, or a plain ack for writes). There is no
// back-pressure on responses.
//
// Modports:
//   slave  - the arbiter side (takes requests and ram_dout, drives the rest)
//   master - the requester/RAM side (drives requests and ram_dout)
interface dmem_arbiter_if;
  // port 0: CPU load/store
  logic        req0;
  logic        we0;
  logic [31:0] addr0;
  logic [3:0]  wmask0;
  logic [31:0] wdata0;
  logic        gnt0;
  logic        rvalid0;
  logic [31:0] rdata0;
  // port 1: loader/debug
  logic        req1;
  logic        we1;
  logic [31:0] addr1;
  logic [3:0]  wmask1;
  logic [31:0] wdata1;
  logic        gnt1;
  logic        rvalid1;
  logic [31:0] rdata1;
  // single-port data RAM
  logic        ram_en;
  logic [3:0]  ram_wea;
  logic [31:0] ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  // response outstanding
  logic        busy;

  modport slave (
    input  req0, we0, addr0, wmask0, wdata0,
    input  req1, we1, addr1, wmask1, wdata1,
    input  ram_dout,
    output gnt0, rvalid0, rdata0,
    output gnt1, rvalid1, rdata1,
    output ram_en, ram_wea, ram_addr, ram_din,
    output busy
  );

  modport master (
    output req0, we0, addr0, wmask0, wdata0,
    output req1, we1, addr1, wmask1, wdata1,
    output ram_dout,
    input  gnt0, rvalid0, rdata0,
    input  gnt1, rvalid1, rdata1,
    input  ram_en, ram_wea, ram_addr, ram_din,
    input  busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares one single-port, byte-masked 32-bit data RAM between the CPU data
// port (port 0, priority) and the loader/debug port (port 1). Port 1 is
// protected from starvation: once it has been refused MAX_WAIT consecutive
// cycles while requesting, it wins the next arbitration.
// One access is issued per cycle; its response (read data or write ack)
// appears one cycle after the grant, so back-to-back issue runs at full rate.
//
// Ports:
//   clka         clock, all state updates on the rising edge
//   rst          asynchronous active-low reset
//   bus          dmem_arbiter_if.slave (requesters, RAM, busy)
//   dbg_wait_cnt current value of the port 1 starvation counter
//
// Parameters:
//   MAX_WAIT  refusals tolerated on port 1 before it is forced through (1..15)
//   CNT_W     starvation counter width, must be able to hold MAX_WAIT
module dmem_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 4
) (
  input  logic               clka,
  input  logic               rst,
  dmem_arbiter_if.slave      bus,
  output logic [CNT_W-1:0]   dbg_wait_cnt
);

  localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);

  logic             resp_vld;
  logic             resp_own;
  logic             resp_we;
  logic [CNT_W-1:0] wait_cnt;

  logic             starve;
  logic             sel0;
  logic             sel1;
  logic             win_we;
  logic [CNT_W-1:0] wait_cnt_nxt;

  // Sub-word address bits never reach the RAM; the RAM is word addressed.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr0[1:0], bus.addr1[1:0]};

  // Arbitration and RAM drive. Everything here is gated with rst so that
  // the combinational outputs are forced low while reset is held, even if
  // a requester keeps its request up.
  always_comb begin
    starve       = 1'b0;
    sel0         = 1'b0;
    sel1         = 1'b0;
    win_we       = 1'b0;
    bus.gnt0     = 1'b0;
    bus.gnt1     = 1'b0;
    bus.ram_en   = 1'b0;
    bus.ram_wea  = 4'b0000;
    bus.ram_addr = 32'h0;
    bus.ram_din  = 32'h0;

    starve = bus.req1 && (wait_cnt >= MAX_WAIT_C);
    sel1   = rst && bus.req1 && (!bus.req0 || starve);
    sel0   = rst && bus.req0 && !sel1;

    bus.gnt0 = sel0;
    bus.gnt1 = sel1;

    if (sel1) begin
      win_we       = bus.we1;
      bus.ram_en   = 1'b1;
      bus.ram_addr = {bus.addr1[31:2], 2'b00};
      bus.ram_din  = bus.wdata1;
      bus.ram_wea  = bus.we1 ? bus.wmask1 : 4'b0000;
    end else if (sel0) begin
      win_we       = bus.we0;
      bus.ram_en   = 1'b1;
      bus.ram_addr = {bus.addr0[31:2], 2'b00};
      bus.ram_din  = bus.wdata0;
      bus.ram_wea  = bus.we0 ? bus.wmask0 : 4'b0000;
    end
  end

  // Starvation counter: counts consecutive refused cycles of a requesting
  // port 1, saturating at MAX_WAIT; any grant to port 1 or an idle port 1
  // clears it.
  always_comb begin
    wait_cnt_nxt = wait_cnt;
    if (sel1 || !bus.req1) begin
      wait_cnt_nxt = '0;
    end else if (wait_cnt < MAX_WAIT_C) begin
      wait_cnt_nxt = wait_cnt + CNT_W'(1);
    end
  end

  // Response tracking. A reset with a response pending simply drops it.
  always_ff @(posedge clka or negedge rst) begin
    if (!rst) begin
      resp_vld <= 1'b0;
      resp_own <= 1'b0;
      resp_we  <= 1'b0;
      wait_cnt <= '0;
    end else begin
      resp_vld <= sel0 || sel1;
      resp_own <= sel1;
      resp_we  <= win_we;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Write acks carry zero data; only reads forward the RAM output.
  always_comb begin
    bus.rvalid0 = resp_vld && !resp_own;
    bus.rvalid1 = resp_vld && resp_own;
    bus.rdata0  = (bus.rvalid0 && !resp_we) ? bus.ram_dout : 32'h0;
    bus.rdata1  = (bus.rvalid1 && !resp_we) ? bus.ram_dout : 32'h0;
    bus.busy    = resp_vld;
  end

  assign dbg_wait_cnt = wait_cnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 4;
  localparam int NCYC     = 300;

  logic             clka = 1'b0;
  logic             rst;
  logic [CNT_W-1:0] dbg_wait_cnt;
  int               errors = 0;
  int               checks = 0;

  dmem_arbiter_if bus();

  dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clka         (clka),
    .rst          (rst),
    .bus          (bus),
    .dbg_wait_cnt (dbg_wait_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clka = ~clka;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- RAM environment (one-cycle read latency) ----------------
  logic        ram_clear;
  logic [31:0] ram [0:63];
  always @(posedge clka) begin
    if (ram_clear) begin
      for (int i = 0; i < 64; i++) ram[i] <= 32'h0;
      bus.ram_dout <= 32'h0;
    end else if (bus.ram_en) begin
      bus.ram_dout <= ram[bus.ram_addr[7:2]];
      for (int b = 0; b < 4; b++)
        if (bus.ram_wea[b]) ram[bus.ram_addr[7:2]][b*8 +: 8] <= bus.ram_din[b*8 +: 8];
    end
  end

  // ---------------- reference model state ----------------
  logic [31:0] ref_mem [0:63];
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clka);
    #1;
  endtask

  task automatic mid();
    @(negedge clka);
  endtask

  task automatic idle_inputs();
    bus.req0 = 0; bus.we0 = 0; bus.addr0 = 0; bus.wmask0 = 0; bus.wdata0 = 0;
    bus.req1 = 0; bus.we1 = 0; bus.addr1 = 0; bus.wmask1 = 0; bus.wdata1 = 0;
  endtask

  task automatic ref_write(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
    for (int b = 0; b < 4; b++)
      if (m[b]) ref_mem[a[7:2]][b*8 +: 8] = d[b*8 +: 8];
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    bus.req0 = 1; bus.addr0 = 32'h40;
    rst = 0; ram_clear = 1;
    step(); step();
    ram_clear = 0;
    mid();
    checks++; if (bus.gnt0 !== 1'b0) begin errors++; $display("FAIL rst_gnt0: got %b want 0", bus.gnt0); end
    checks++; if (bus.ram_en !== 1'b0) begin errors++; $display("FAIL rst_ram_en: got %b want 0", bus.ram_en); end
    checks++; if (bus.ram_addr !== 32'h0) begin errors++; $display("FAIL rst_ram_addr: got %h want 0", bus.ram_addr); end
    checks++; if (bus.rvalid0 !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL rst_resp: rvalid0=%b busy=%b want 0/0", bus.rvalid0, bus.busy); end
    checks++; if (dbg_wait_cnt !== '0) begin errors++; $display("FAIL rst_wait_cnt: got %0d want 0", dbg_wait_cnt); end
    // release mid-cycle: grant is combinational, visible immediately
    #1 rst = 1;
    #1;
    checks++; if (bus.gnt0 !== 1'b1 || bus.ram_en !== 1'b1) begin errors++; $display("FAIL rel_gnt0: gnt0=%b ram_en=%b want 1/1", bus.gnt0, bus.ram_en); end
    checks++; if (bus.ram_addr !== 32'h40) begin errors++; $display("FAIL rel_addr: got %h want 40", bus.ram_addr); end
    step();
    mid();
    checks++; if (bus.busy !== 1'b1 || bus.rvalid0 !== 1'b1) begin errors++; $display("FAIL rel_resp: busy=%b rvalid0=%b want 1/1", bus.busy, bus.rvalid0); end
    // assert reset mid-cycle with the request still up
    #1 rst = 0;
    #1;
    checks++; if (bus.gnt0 !== 1'b0 || bus.ram_en !== 1'b0) begin errors++; $display("FAIL mid_rst_gnt: gnt0=%b ram_en=%b want 0/0", bus.gnt0, bus.ram_en); end
    checks++; if (bus.rvalid0 !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL mid_rst_resp: rvalid0=%b busy=%b want 0/0", bus.rvalid0, bus.busy); end
    bus.req0 = 0;
    step();
    rst = 1;
    step();
  endtask

  task automatic test_wr_rd();
    idle_inputs();
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 32'h0000_0013; bus.wmask0 = 4'b0011; bus.wdata0 = 32'hAABB_CCDD;
    mid();
    checks++; if (bus.gnt0 !== 1'b1 || bus.ram_en !== 1'b1) begin errors++; $display("FAIL wr_gnt: gnt0=%b ram_en=%b want 1/1", bus.gnt0, bus.ram_en); end
    checks++; if (bus.ram_addr !== 32'h10) begin errors++; $display("FAIL wr_addr: got %h want 10", bus.ram_addr); end
    checks++; if (bus.ram_wea !== 4'b0011) begin errors++; $display("FAIL wr_wea: got %b want 0011", bus.ram_wea); end
    checks++; if (bus.ram_din !== 32'hAABB_CCDD) begin errors++; $display("FAIL wr_din: got %h want aabbccdd", bus.ram_din); end
    ref_write(32'h13, 4'b0011, 32'hAABB_CCDD);
    step();
    bus.we0 = 0; bus.addr0 = 32'h10; bus.wmask0 = 4'b1111;
    mid();
    checks++; if (bus.rvalid0 !== 1'b1 || bus.rdata0 !== 32'h0) begin errors++; $display("FAIL wr_ack: rvalid0=%b rdata0=%h want 1/0", bus.rvalid0, bus.rdata0); end
    checks++; if (bus.gnt0 !== 1'b1 || bus.ram_wea !== 4'b0000) begin errors++; $display("FAIL rd_issue: gnt0=%b wea=%b want 1/0000", bus.gnt0, bus.ram_wea); end
    step();
    bus.req0 = 0;
    mid();
    checks++; if (bus.rvalid0 !== 1'b1 || bus.rdata0 !== 32'h0000_CCDD) begin errors++; $display("FAIL rd_data: rvalid0=%b rdata0=%h want 1/0000ccdd", bus.rvalid0, bus.rdata0); end
    checks++; if (bus.rdata0 !== ref_mem[4]) begin errors++; $display("FAIL rd_model: got %h want %h", bus.rdata0, ref_mem[4]); end
    step();
    mid();
    checks++; if (bus.rvalid0 !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL rd_done: rvalid0=%b busy=%b want 0/0", bus.rvalid0, bus.busy); end
    step();
  endtask

  task automatic test_random();
    logic        p0, p1, eg0, eg1, w;
    logic [31:0] a, d, e;
    logic [3:0]  m;
    int          r1;
    idle_inputs();
    p0 = 0; p1 = 0; r1 = 0;
    for (int c = 0; c < NCYC; c++) begin
      if (c < NCYC - 10) begin
        if (!p0 && $urandom_range(0, 99) < 60) begin
          p0 = 1; bus.we0 = 1'($urandom_range(0, 1)); bus.addr0 = $urandom;
          bus.wmask0 = 4'($urandom_range(0, 15)); bus.wdata0 = $urandom;
        end
        if (!p1 && $urandom_range(0, 99) < 50) begin
          p1 = 1; bus.we1 = 1'($urandom_range(0, 1)); bus.addr1 = $urandom;
          bus.wmask1 = 4'($urandom_range(0, 15)); bus.wdata1 = $urandom;
        end else if (p1 && $urandom_range(0, 99) < 5) begin
          p1 = 0;  // loader withdraws after being refused
        end
      end
      bus.req0 = p0; bus.req1 = p1;
      mid();
      // fixed priority, port 1 forced through after MAX_WAIT refusals
      eg1 = p1 && (!p0 || r1 >= MAX_WAIT);
      eg0 = p0 && !eg1;
      checks++; if (bus.gnt0 !== eg0 || bus.gnt1 !== eg1) begin errors++; $display("FAIL rnd_gnt c=%0d: gnt0/1=%b%b want %b%b", c, bus.gnt0, bus.gnt1, eg0, eg1); end
      checks++; if (dbg_wait_cnt !== CNT_W'(r1)) begin errors++; $display("FAIL rnd_wait c=%0d: got %0d want %0d", c, dbg_wait_cnt, r1); end
      if (eg0 || eg1) begin
        w = eg1 ? bus.we1 : bus.we0;
        a = eg1 ? bus.addr1 : bus.addr0;
        m = eg1 ? bus.wmask1 : bus.wmask0;
        d = eg1 ? bus.wdata1 : bus.wdata0;
        checks++;
        if (bus.ram_en !== 1'b1 || bus.ram_addr !== {a[31:2], 2'b00} || bus.ram_wea !== (w ? m : 4'b0000) || bus.ram_din !== d) begin
          errors++;
          $display("FAIL rnd_ram c=%0d: en=%b addr=%h wea=%b din=%h want 1 %h %b %h", c, bus.ram_en, bus.ram_addr, bus.ram_wea, bus.ram_din, {a[31:2], 2'b00}, (w ? m : 4'b0000), d);
        end
      end else begin
        checks++; if (bus.ram_en !== 1'b0 || bus.ram_wea !== 4'b0000) begin errors++; $display("FAIL rnd_idle c=%0d: en=%b wea=%b want 0/0000", c, bus.ram_en, bus.ram_wea); end
      end
      // responses owed from last cycle
      checks++;
      if (bus.rvalid0 !== (exp_q0.size() != 0)) begin errors++; $display("FAIL rnd_rvalid0 c=%0d: got %b want %b", c, bus.rvalid0, exp_q0.size() != 0); end
      if (exp_q0.size() != 0) begin
        e = exp_q0.pop_front();
        checks++; if (bus.rdata0 !== e) begin errors++; $display("FAIL rnd_rdata0 c=%0d: got %h want %h", c, bus.rdata0, e); end
      end else begin
        checks++; if (bus.rdata0 !== 32'h0) begin errors++; $display("FAIL rnd_rdata0_idle c=%0d: got %h want 0", c, bus.rdata0); end
      end
      checks++;
      if (bus.rvalid1 !== (exp_q1.size() != 0)) begin errors++; $display("FAIL rnd_rvalid1 c=%0d: got %b want %b", c, bus.rvalid1, exp_q1.size() != 0); end
      if (exp_q1.size() != 0) begin
        e = exp_q1.pop_front();
        checks++; if (bus.rdata1 !== e) begin errors++; $display("FAIL rnd_rdata1 c=%0d: got %h want %h", c, bus.rdata1, e); end
      end else begin
        checks++; if (bus.rdata1 !== 32'h0) begin errors++; $display("FAIL rnd_rdata1_idle c=%0d: got %h want 0", c, bus.rdata1); end
      end
      // advance the model
      if (eg0 || eg1) begin
        if (w) begin
          e = 32'h0;
          ref_write(a, m, d);
        end else begin
          e = ref_mem[a[7:2]];
        end
        if (eg1) exp_q1.push_back(e); else exp_q0.push_back(e);
      end
      r1 = (p1 && !eg1) ? ((r1 < MAX_WAIT) ? r1 + 1 : MAX_WAIT) : 0;
      step();
      if (eg0) p0 = 0;
      if (eg1) p1 = 0;
      bus.req0 = p0; bus.req1 = p1;
    end
    idle_inputs();
    step();
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    step();
    for (int k = 0; k < 4; k++) begin
      if (k < 3) begin bus.req0 = 1; bus.we0 = 0; bus.addr0 = 32'(k * 4); end
      else bus.req0 = 0;
      mid();
      if (k < 3) begin
        checks++; if (bus.gnt0 !== 1'b1 || bus.ram_addr !== 32'(k * 4)) begin errors++; $display("FAIL b2b_gnt k=%0d: gnt0=%b addr=%h want 1 %h", k, bus.gnt0, bus.ram_addr, 32'(k * 4)); end
      end else begin
        checks++; if (bus.gnt0 !== 1'b0) begin errors++; $display("FAIL b2b_gnt_end: got %b want 0", bus.gnt0); end
      end
      if (k > 0) begin
        checks++; if (bus.rvalid0 !== 1'b1 || bus.rdata0 !== ref_mem[k-1]) begin errors++; $display("FAIL b2b_resp k=%0d: rvalid0=%b rdata0=%h want 1 %h", k, bus.rvalid0, bus.rdata0, ref_mem[k-1]); end
      end else begin
        checks++; if (bus.rvalid0 !== 1'b0) begin errors++; $display("FAIL b2b_resp0: got %b want 0", bus.rvalid0); end
      end
      step();
    end
    mid();
    checks++; if (bus.rvalid0 !== 1'b0) begin errors++; $display("FAIL b2b_tail: got %b want 0", bus.rvalid0); end
    step();
  endtask

  task automatic test_port1_alone();
    logic [31:0] d;
    idle_inputs();
    d = $urandom | 32'h0100_0000;
    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 32'h20; bus.wmask1 = 4'b1111; bus.wdata1 = d;
    mid();
    checks++; if (bus.gnt1 !== 1'b1 || bus.gnt0 !== 1'b0) begin errors++; $display("FAIL p1_wr_gnt: gnt1=%b gnt0=%b want 1/0", bus.gnt1, bus.gnt0); end
    checks++; if (dbg_wait_cnt !== '0) begin errors++; $display("FAIL p1_wait: got %0d want 0", dbg_wait_cnt); end
    ref_write(32'h20, 4'b1111, d);
    step();
    bus.we1 = 0;
    mid();
    checks++; if (bus.gnt1 !== 1'b1 || bus.ram_addr !== 32'h20) begin errors++; $display("FAIL p1_rd_gnt: gnt1=%b addr=%h want 1 20", bus.gnt1, bus.ram_addr); end
    checks++; if (bus.rvalid1 !== 1'b1 || bus.rdata1 !== 32'h0) begin errors++; $display("FAIL p1_wr_ack: rvalid1=%b rdata1=%h want 1/0", bus.rvalid1, bus.rdata1); end
    step();
    bus.req1 = 0;
    mid();
    checks++; if (bus.rvalid1 !== 1'b1 || bus.rdata1 !== ref_mem[8]) begin errors++; $display("FAIL p1_rd_data: rvalid1=%b rdata1=%h want 1 %h", bus.rvalid1, bus.rdata1, ref_mem[8]); end
    checks++; if (bus.rvalid0 !== 1'b0 || bus.rdata0 !== 32'h0) begin errors++; $display("FAIL p1_port0_quiet: rvalid0=%b rdata0=%h want 0/0", bus.rvalid0, bus.rdata0); end
    checks++; if (dbg_wait_cnt !== '0) begin errors++; $display("FAIL p1_wait_end: got %0d want 0", dbg_wait_cnt); end
    step();
  endtask

  task automatic test_contention();
    logic prev1, exp1;
    idle_inputs();
    step();
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 32'h4;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 32'h8;
    prev1 = 0;
    for (int i = 0; i < 15; i++) begin
      mid();
      exp1 = (i % (MAX_WAIT + 1)) == MAX_WAIT;
      checks++; if (bus.gnt1 !== exp1 || bus.gnt0 !== !exp1) begin errors++; $display("FAIL cont_gnt i=%0d: gnt0/1=%b%b want %b%b", i, bus.gnt0, bus.gnt1, !exp1, exp1); end
      checks++; if (dbg_wait_cnt !== CNT_W'(i % (MAX_WAIT + 1))) begin errors++; $display("FAIL cont_wait i=%0d: got %0d want %0d", i, dbg_wait_cnt, i % (MAX_WAIT + 1)); end
      if (i > 0) begin
        checks++; if (bus.rvalid1 !== prev1 || bus.rvalid0 !== !prev1) begin errors++; $display("FAIL cont_rvalid i=%0d: rvalid0/1=%b%b want %b%b", i, bus.rvalid0, bus.rvalid1, !prev1, prev1); end
        checks++; if (bus.rdata0 !== (prev1 ? 32'h0 : ref_mem[1]) || bus.rdata1 !== (prev1 ? ref_mem[2] : 32'h0)) begin errors++; $display("FAIL cont_rdata i=%0d: rdata0=%h rdata1=%h", i, bus.rdata0, bus.rdata1); end
      end
      prev1 = exp1;
      step();
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid_read();
    idle_inputs();
    bus.req0 = 1; bus.addr0 = 32'h0;
    bus.req1 = 1; bus.addr1 = 32'h30;
    step(); step();  // port 1 refused twice
    bus.req0 = 0;
    mid();
    checks++; if (bus.gnt1 !== 1'b1 || dbg_wait_cnt !== CNT_W'(2)) begin errors++; $display("FAIL rmr_pre: gnt1=%b wait=%0d want 1/2", bus.gnt1, dbg_wait_cnt); end
    #2 rst = 0;
    #1;
    checks++; if (bus.gnt1 !== 1'b0 || dbg_wait_cnt !== '0 || bus.busy !== 1'b0) begin errors++; $display("FAIL rmr_rst: gnt1=%b wait=%0d busy=%b want 0/0/0", bus.gnt1, dbg_wait_cnt, bus.busy); end
    step();
    mid();
    checks++; if (bus.rvalid1 !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL rmr_no_resp: rvalid1=%b busy=%b want 0/0", bus.rvalid1, bus.busy); end
    bus.req1 = 0;
    step();
    rst = 1;
    mid();
    checks++; if (bus.rvalid1 !== 1'b0 || bus.busy !== 1'b0 || dbg_wait_cnt !== '0) begin errors++; $display("FAIL rmr_after: rvalid1=%b busy=%b wait=%0d want 0/0/0", bus.rvalid1, bus.busy, dbg_wait_cnt); end
    step();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 0;
    ram_clear = 1;
    idle_inputs();
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
    test_reset();
    test_wr_rd();
    test_random();
    test_back_to_back();
    test_port1_alone();
    test_contention();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
